// File: rtl/rose_implication_monitor.sv
// Multi-channel hardware checker for "rise on ant[i] implies rise on cons[i]
// within MIN_DLY..MAX_DLY cycles", with verdict pulses and saturating counters.
module rose_implication_monitor #(
  parameter int NUM_CH  = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 1,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    clr_cnt,
  input  logic [NUM_CH-1:0]       ant,
  input  logic [NUM_CH-1:0]       cons,
  output logic [NUM_CH-1:0]       pass_pulse,
  output logic [NUM_CH-1:0]       fail_pulse,
  output logic [NUM_CH-1:0]       ovl_pulse,
  output logic [NUM_CH*CNT_W-1:0] pass_cnt,
  output logic [NUM_CH*CNT_W-1:0] fail_cnt,
  output logic                    busy
);

  localparam int DLY_W = $clog2(MAX_DLY + 1);
  localparam logic [DLY_W-1:0] MIN_V = DLY_W'(MIN_DLY);
  localparam logic [DLY_W-1:0] MAX_V = DLY_W'(MAX_DLY);

  typedef enum logic {S_IDLE, S_ARMED} state_t;

  state_t             r_state     [NUM_CH];
  state_t             w_state_nxt [NUM_CH];
  logic [DLY_W-1:0]   r_dly       [NUM_CH];
  logic [DLY_W-1:0]   w_dly_nxt   [NUM_CH];
  logic [CNT_W-1:0]   r_pass_cnt  [NUM_CH];
  logic [CNT_W-1:0]   r_fail_cnt  [NUM_CH];

  logic [NUM_CH-1:0]  r_ant_q, r_cons_q;
  logic [NUM_CH-1:0]  w_rose_ant, w_rose_cons;
  logic [NUM_CH-1:0]  w_pass, w_fail, w_ovl, w_armed;
  logic [NUM_CH-1:0]  r_pass, r_fail, r_ovl;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ant_q  <= '0;
      r_cons_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= S_IDLE;
        r_dly[i]   <= '0;
      end
    end else begin
      r_ant_q  <= ant;
      r_cons_q <= cons;
      for (int i = 0; i < NUM_CH; i++) begin
        r_state[i] <= w_state_nxt[i];
        r_dly[i]   <= w_dly_nxt[i];
      end
    end
  end

  always_comb begin
    w_rose_ant  = ant & ~r_ant_q;
    w_rose_cons = cons & ~r_cons_q;
    w_pass      = '0;
    w_fail      = '0;
    w_ovl       = '0;
    w_armed     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_state_nxt[i] = r_state[i];
      w_dly_nxt[i]   = r_dly[i];
      w_armed[i]     = (r_state[i] == S_ARMED);
      if (!enable) begin
        w_state_nxt[i] = S_IDLE;
        w_dly_nxt[i]   = '0;
      end else if (r_state[i] == S_IDLE) begin
        if (w_rose_ant[i]) begin
          w_state_nxt[i] = S_ARMED;
          w_dly_nxt[i]   = DLY_W'(1);
        end
      end else begin
        // A qualifying consequent wins over the deadline at k == MAX_DLY.
        if (w_rose_cons[i] && (r_dly[i] >= MIN_V)) w_pass[i] = 1'b1;
        else if (r_dly[i] == MAX_V)                w_fail[i] = 1'b1;
        if (w_pass[i] || w_fail[i]) begin
          w_state_nxt[i] = w_rose_ant[i] ? S_ARMED : S_IDLE;
          w_dly_nxt[i]   = w_rose_ant[i] ? DLY_W'(1) : '0;
        end else begin
          w_dly_nxt[i] = r_dly[i] + DLY_W'(1);
          w_ovl[i]     = w_rose_ant[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass <= '0;
      r_fail <= '0;
      r_ovl  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_pass_cnt[i] <= '0;
        r_fail_cnt[i] <= '0;
      end
    end else begin
      r_pass <= w_pass;
      r_fail <= w_fail;
      r_ovl  <= w_ovl;
      for (int i = 0; i < NUM_CH; i++) begin
        if (clr_cnt) begin
          r_pass_cnt[i] <= '0;
          r_fail_cnt[i] <= '0;
        end else begin
          if (w_pass[i]) r_pass_cnt[i] <= sat_inc(r_pass_cnt[i]);
          if (w_fail[i]) r_fail_cnt[i] <= sat_inc(r_fail_cnt[i]);
        end
      end
    end
  end

  always_comb begin
    pass_pulse = r_pass;
    fail_pulse = r_fail;
    ovl_pulse  = r_ovl;
    busy       = |w_armed;
    pass_cnt   = '0;
    fail_cnt   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pass_cnt[i*CNT_W +: CNT_W] = r_pass_cnt[i];
      fail_cnt[i*CNT_W +: CNT_W] = r_fail_cnt[i];
    end
  end

endmodule

// File: tb/tb_rose_implication_monitor.sv
// Bench: two monitor instances (1..1/16-bit and 2..4/3-bit) driven in parallel and
// compared each cycle against a time-stamp based reference model.
module tb_rose_implication_monitor;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          enable, clr_cnt;
  logic [N-1:0]  ant, cons;
  logic [N-1:0]  pass_a, fail_a, ovl_a, pass_b, fail_b, ovl_b;
  logic [N*16-1:0] pcnt_a, fcnt_a;
  logic [N*3-1:0]  pcnt_b, fcnt_b;
  logic          busy_a, busy_b;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rose_implication_monitor #(.NUM_CH(N), .MIN_DLY(1), .MAX_DLY(1), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_cnt(clr_cnt),
    .ant(ant), .cons(cons), .pass_pulse(pass_a), .fail_pulse(fail_a),
    .ovl_pulse(ovl_a), .pass_cnt(pcnt_a), .fail_cnt(fcnt_a), .busy(busy_a));

  rose_implication_monitor #(.NUM_CH(N), .MIN_DLY(2), .MAX_DLY(4), .CNT_W(3)) u_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .clr_cnt(clr_cnt),
    .ant(ant), .cons(cons), .pass_pulse(pass_b), .fail_pulse(fail_b),
    .ovl_pulse(ovl_b), .pass_cnt(pcnt_b), .fail_cnt(fcnt_b), .busy(busy_b));

  // Reference model: an attempt is remembered by the cycle number of its rise.
  int MINV [2] = '{1, 2};
  int MAXV [2] = '{1, 4};
  int CMAX [2] = '{65535, 7};
  int t0   [2][N];
  int e_pc [2][N];
  int e_fc [2][N];
  logic [N-1:0] e_pass [2];
  logic [N-1:0] e_fail [2];
  logic [N-1:0] e_ovl  [2];
  logic         e_busy [2];
  logic [N-1:0] m_ant_q, m_cons_q;
  int cyc = 0;

  task automatic model_reset();
    m_ant_q  = '0;
    m_cons_q = '0;
    for (int c = 0; c < 2; c++) begin
      e_pass[c] = '0; e_fail[c] = '0; e_ovl[c] = '0; e_busy[c] = 1'b0;
      for (int i = 0; i < N; i++) begin
        t0[c][i] = -1; e_pc[c][i] = 0; e_fc[c][i] = 0;
      end
    end
  endtask

  task automatic model_step();
    logic [N-1:0] ra, rc;
    logic verdict;
    int k;
    ra = ant & ~m_ant_q;
    rc = cons & ~m_cons_q;
    for (int c = 0; c < 2; c++) begin
      e_pass[c] = '0; e_fail[c] = '0; e_ovl[c] = '0; e_busy[c] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!enable) begin
          t0[c][i] = -1;
        end else begin
          verdict = 1'b0;
          if (t0[c][i] >= 0) begin
            k = cyc - t0[c][i];
            if (rc[i] && k >= MINV[c]) begin e_pass[c][i] = 1'b1; verdict = 1'b1; end
            else if (k == MAXV[c])     begin e_fail[c][i] = 1'b1; verdict = 1'b1; end
            else if (ra[i])            e_ovl[c][i] = 1'b1;
          end
          if (t0[c][i] < 0 || verdict) t0[c][i] = ra[i] ? cyc : -1;
        end
        if (clr_cnt) begin
          e_pc[c][i] = 0; e_fc[c][i] = 0;
        end else begin
          if (e_pass[c][i] && e_pc[c][i] < CMAX[c]) e_pc[c][i]++;
          if (e_fail[c][i] && e_fc[c][i] < CMAX[c]) e_fc[c][i]++;
        end
        if (t0[c][i] >= 0) e_busy[c] = 1'b1;
      end
    end
    m_ant_q  = ant;
    m_cons_q = cons;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".passA"}, 64'(pass_a), 64'(e_pass[0]));
    chk({tag, ".failA"}, 64'(fail_a), 64'(e_fail[0]));
    chk({tag, ".ovlA"},  64'(ovl_a),  64'(e_ovl[0]));
    chk({tag, ".busyA"}, 64'(busy_a), 64'(e_busy[0]));
    chk({tag, ".passB"}, 64'(pass_b), 64'(e_pass[1]));
    chk({tag, ".failB"}, 64'(fail_b), 64'(e_fail[1]));
    chk({tag, ".ovlB"},  64'(ovl_b),  64'(e_ovl[1]));
    chk({tag, ".busyB"}, 64'(busy_b), 64'(e_busy[1]));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s.pcntA%0d", tag, i), 64'(pcnt_a[i*16 +: 16]), 64'(e_pc[0][i]));
      chk($sformatf("%s.fcntA%0d", tag, i), 64'(fcnt_a[i*16 +: 16]), 64'(e_fc[0][i]));
      chk($sformatf("%s.pcntB%0d", tag, i), 64'(pcnt_b[i*3 +: 3]),   64'(e_pc[1][i]));
      chk($sformatf("%s.fcntB%0d", tag, i), 64'(fcnt_b[i*3 +: 3]),   64'(e_fc[1][i]));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input int n);
    ant = '0; cons = '0;
    repeat (n) step("idle");
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; clr_cnt = 1'b0; ant = '0; cons = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b1;
    idle(2);

    // basic pass on channel 0
    ant = 4'b0001; step("t1.rise");
    cons = 4'b0001; step("t1.cons");
    chk("t1.pass0", 64'(pass_a[0]), 64'd1);
    chk("t1.pcnt0", 64'(pcnt_a[15:0]), 64'd1);
    chk("t1.fcnt0", 64'(fcnt_a[15:0]), 64'd0);
    idle(6);

    // basic fail on channel 1, then with cons already high
    ant = 4'b0010; step("t2.rise");
    step("t2.fail");
    chk("t2.fail1", 64'(fail_a[1]), 64'd1);
    chk("t2.fcnt1", 64'(fcnt_a[31:16]), 64'd1);
    idle(6);
    cons = 4'b0010; step("t2b.cons");
    ant = 4'b0010; step("t2b.rise");
    step("t2b.fail");
    chk("t2b.fail1", 64'(fail_a[1]), 64'd1);
    chk("t2b.fcnt1", 64'(fcnt_a[31:16]), 64'd2);
    idle(6);

    // window 2..4 on instance B, channel 2
    ant = 4'b0100; step("t3.rise");
    cons = 4'b0100; step("t3.k1");
    cons = 4'b0000; step("t3.k2");
    cons = 4'b0100; step("t3.k3");
    chk("t3.pass2_k3", 64'(pass_b[2]), 64'd1);
    idle(6);
    ant = 4'b0100; step("t3f.rise");
    ant = 4'b0000;
    repeat (3) step("t3f.wait");
    chk("t3f.nofail_k3", 64'(fail_b[2]), 64'd0);
    step("t3f.k4");
    chk("t3f.fail2_k4", 64'(fail_b[2]), 64'd1);
    idle(6);
    ant = 4'b0100; step("t3p.rise");
    ant = 4'b0000;
    repeat (3) step("t3p.wait");
    cons = 4'b0100; step("t3p.k4");
    chk("t3p.pass2_k4", 64'(pass_b[2]), 64'd1);
    chk("t3p.nofail2", 64'(fail_b[2]), 64'd0);
    idle(6);

    // overlap and back-to-back on channel 3
    ant = 4'b1000; step("t4.rise");
    ant = 4'b0000; step("t4.k1");
    ant = 4'b1000; step("t4.k2");
    chk("t4.ovl3", 64'(ovl_b[3]), 64'd1);
    ant = 4'b0000; step("t4.k3");
    step("t4.k4");
    chk("t4.fail3", 64'(fail_b[3]), 64'd1);
    idle(6);
    ant = 4'b1000; step("t4b.rise");
    ant = 4'b0000; step("t4b.k1");
    ant = 4'b1000; cons = 4'b1000; step("t4b.k2");
    chk("t4b.pass3", 64'(pass_b[3]), 64'd1);
    chk("t4b.busyB", 64'(busy_b), 64'd1);
    ant = 4'b0000; cons = 4'b0000; step("t4b.r1");
    cons = 4'b1000; step("t4b.r2");
    chk("t4b.pass3_again", 64'(pass_b[3]), 64'd1);
    idle(6);

    // saturation and clear on instance B channel 0
    for (int n = 0; n < 9; n++) begin
      ant = 4'b0001; step("t5.rise");
      ant = 4'b0000; step("t5.k1");
      cons = 4'b0001; step("t5.k2");
      cons = 4'b0000; step("t5.gap");
    end
    chk("t5.sat", 64'(pcnt_b[2:0]), 64'd7);
    ant = 4'b0001; step("t5c.rise");
    ant = 4'b0000; step("t5c.k1");
    cons = 4'b0001; clr_cnt = 1'b1; step("t5c.k2");
    chk("t5c.pass0", 64'(pass_b[0]), 64'd1);
    chk("t5c.pcnt0", 64'(pcnt_b[2:0]), 64'd0);
    clr_cnt = 1'b0;
    idle(6);

    // reset while armed
    ant = 4'b0010; step("t6.rise");
    ant = 4'b0000; step("t6.k1");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("t6.rst");
    chk("t6.busyB", 64'(busy_b), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);

    // enable dropped while armed
    ant = 4'b0010; step("t6e.rise");
    ant = 4'b0000; step("t6e.k1");
    enable = 1'b0; step("t6e.off");
    chk("t6e.busyB", 64'(busy_b), 64'd0);
    chk("t6e.nofail", 64'(fail_b), 64'd0);
    enable = 1'b1;
    idle(6);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      ant     = N'($urandom);
      cons    = N'($urandom);
      enable  = ($urandom_range(0, 15) != 0);
      clr_cnt = ($urandom_range(0, 40) == 0);
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
